// File: rtl/tt_um_as_pattern_sequencer.sv
// Pattern sequencer: loads up to DEPTH bytes through uio_in and replays them on uo_out.
// Optional SEQ_CHECKSUM_EN adds an XOR checksum of loaded bytes, shown on uo_out while idle.
module tt_um_as_pattern_sequencer #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = 6;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    DONE = 2'b10,
    BAD  = 2'b11
  } state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [AW-1:0] rptr;
  logic [3:0]    tick;
  logic [7:0]    mem [DEPTH];

  logic [7:0] sync_q [SYNC_STAGES];
  logic [1:0] edge_d1;
  logic [7:0] synced;
  logic       wr_edge, clr_edge, run, loop_en;
  logic [3:0] div;
  logic       wr_acc, clr_acc, last_word;
  logic [AW-1:0] rptr_inc;
  logic [7:0] idle_val;

  // Control synchroniser plus previous-value flops for the two edge-triggered bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      edge_d1 <= '0;
    end else if (ena) begin
      sync_q[0] <= ui_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      edge_d1 <= {synced[3], synced[0]};
    end
  end

  assign synced   = sync_q[SYNC_STAGES-1];
  assign wr_edge  = synced[0] & ~edge_d1[0];
  assign clr_edge = synced[3] & ~edge_d1[1];
  assign run      = synced[1];
  assign loop_en  = synced[2];
  assign div      = synced[7:4];

  assign clr_acc   = (state == IDLE) && clr_edge;
  assign wr_acc    = (state == IDLE) && wr_edge && !clr_edge && (count < CW'(DEPTH));
  assign rptr_inc  = rptr + AW'(1);
  assign last_word = ((CW'(rptr) + CW'(1)) == count);

`ifdef SEQ_CHECKSUM_EN
  logic [7:0] csum, csum_nxt;

  always_comb begin
    csum_nxt = csum;
    if (clr_acc)     csum_nxt = '0;
    else if (wr_acc) csum_nxt = csum ^ uio_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   csum <= '0;
    else if (ena) csum <= csum_nxt;
  end

  assign idle_val = csum_nxt;
`else
  assign idle_val = '0;
`endif

  // Pattern memory is intentionally not reset
  always_ff @(posedge clk) begin
    if (ena && wr_acc) mem[count[AW-1:0]] <= uio_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      rptr   <= '0;
      tick   <= '0;
      uo_out <= '0;
      uio_oe <= '0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (clr_acc)     count <= '0;
          else if (wr_acc) count <= count + CW'(1);
          // Start decision uses the count before any same-cycle write
          if (run && (count != '0) && !clr_edge) begin
            state  <= PLAY;
            rptr   <= '0;
            tick   <= '0;
            uo_out <= mem[0];
            uio_oe <= 8'hFF;
          end else begin
            uo_out <= idle_val;
          end
        end
        PLAY: begin
          if (!run) begin
            state  <= IDLE;
            rptr   <= '0;
            uo_out <= idle_val;
            uio_oe <= 8'h00;
          end else if (tick == div) begin
            tick <= '0;
            if (last_word) begin
              if (loop_en) begin
                rptr   <= '0;
                uo_out <= mem[0];
              end else begin
                state <= DONE;
              end
            end else begin
              rptr   <= rptr_inc;
              uo_out <= mem[rptr_inc];
            end
          end else begin
            tick <= tick + 4'd1;
          end
        end
        DONE: begin
          if (!run) begin
            state  <= IDLE;
            uo_out <= idle_val;
            uio_oe <= 8'h00;
          end
        end
        default: begin
          state  <= IDLE;
          rptr   <= '0;
          uo_out <= idle_val;
          uio_oe <= 8'h00;
        end
      endcase
    end
  end

  assign uio_out = {state, count};

endmodule

// File: tb/tb_tt_um_as_pattern_sequencer.sv
// Scoreboard bench for tt_um_as_pattern_sequencer; honours SEQ_CHECKSUM_EN when defined.
module tb_tt_um_as_pattern_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q [$];
  logic [7:0] model_mem [$];
  logic [7:0] csum_m = 8'h00;

  tt_um_as_pattern_sequencer #(.DEPTH(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] idle_exp();
`ifdef SEQ_CHECKSUM_EN
    return csum_m;
`else
    return 8'h00;
`endif
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // sel 0 waits on uio_oe, sel 1 on uo_out; an expired bound shows up as a failed check
  task automatic wait_for(input int sel, input logic [7:0] v, input string tag);
    int n = 0;
    while (((sel == 0) ? uio_oe : uo_out) !== v && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, (sel == 0) ? uio_oe : uo_out, v);
  endtask

  task automatic write_word(input logic [7:0] v);
    uio_in = v;
    ui_in[0] = 1'b1;
    cycles(4);
    ui_in[0] = 1'b0;
    cycles(3);
    if (model_mem.size() < 16) begin
      model_mem.push_back(v);
      csum_m = csum_m ^ v;
    end
  endtask

  task automatic clr_pulse();
    ui_in[3] = 1'b1;
    cycles(4);
    ui_in[3] = 1'b0;
    cycles(3);
    model_mem.delete();
    csum_m = 8'h00;
  endtask

  // Expected replay: each word held div+1 samples, for n_words samples-groups total
  task automatic push_play(input int div, input int n_words, input int extra_last);
    for (int w = 0; w < n_words; w++)
      for (int k = 0; k <= div; k++) exp_q.push_back(model_mem[w % model_mem.size()]);
    for (int k = 0; k < extra_last; k++) exp_q.push_back(model_mem[model_mem.size()-1]);
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) begin
      check(tag, uo_out, exp_q.pop_front());
      @(negedge clk);
    end
  endtask

  task automatic start_run(input logic [3:0] div, input logic loop_en);
    ui_in[7:4] = div;
    ui_in[2]   = loop_en;
    ui_in[1]   = 1'b1;
  endtask

  task automatic stop_run(input string tag);
    ui_in[1] = 1'b0;
    wait_for(0, 8'h00, tag);
    check({tag, "_uo"}, uo_out, idle_exp());
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    cycles(3);
    rst_n = 1'b1;
    cycles(1);
    check("rst_uo", uo_out, 8'h00);
    check("rst_uio_out", uio_out, 8'h00);
    check("rst_oe", uio_oe, 8'h00);

    write_word(8'hA5);
    write_word(8'h3C);
    write_word(8'hFF);
    check("load3_status", uio_out, 8'h03);
    check("load3_idle_uo", uo_out, idle_exp());

    // Frozen design must not see a wr pulse applied only while ena is low
    ena = 1'b0;
    ui_in[0] = 1'b1;
    cycles(5);
    ui_in[0] = 1'b0;
    cycles(2);
    ena = 1'b1;
    cycles(4);
    check("freeze_count", uio_out, 8'h03);

    // One-shot, div=0
    start_run(4'd0, 1'b0);
    wait_for(0, 8'hFF, "oneshot_oe");
    push_play(0, 3, 3);
    drain("oneshot_uo");
    check("done_status", uio_out, 8'h83);
    check("done_oe", uio_oe, 8'hFF);
    stop_run("oneshot_stop");
    check("oneshot_idle_status", uio_out, 8'h03);

    // Looping, div=3: no gap between last word and first word
    start_run(4'd3, 1'b1);
    wait_for(0, 8'hFF, "loop_oe");
    push_play(3, 5, 0);
    drain("loop_uo");
    check("loop_status", uio_out, 8'h43);
    stop_run("loop_stop");

    clr_pulse();
    check("clr_status", uio_out, 8'h00);
    check("clr_uo", uo_out, 8'h00);

    // Overfill: 18 writes, only the first 16 kept
    for (int i = 0; i < 18; i++) write_word(8'h10 + 8'(i));
    check("full_idle_status", uio_out, 8'h10);
    check("full_idle_uo", uo_out, idle_exp());
    start_run(4'd0, 1'b0);
    wait_for(0, 8'hFF, "full_oe");
    check("full_play_status", uio_out, 8'h50);
    push_play(0, 16, 3);
    drain("full_uo");
    stop_run("full_stop");

    // Mid-play abort, then clr, then run on empty memory
    clr_pulse();
    write_word(8'hA5);
    write_word(8'h3C);
    write_word(8'hFF);
    start_run(4'd3, 1'b0);
    wait_for(1, 8'h3C, "abort_word2");
    stop_run("abort");
    check("abort_status", uio_out, 8'h03);
    clr_pulse();
    check("abort_clr_status", uio_out, 8'h00);
    check("abort_clr_uo", uo_out, 8'h00);
    ui_in[1] = 1'b1;
    cycles(8);
    check("empty_run_oe", uio_oe, 8'h00);
    check("empty_run_status", uio_out, 8'h00);
    ui_in[1] = 1'b0;
    cycles(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
